// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam int BYTE_W       = 8;
    localparam int EOP_SE0_BITS = 2;
    localparam int EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer <= '0;
        end else if (timer == LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign bit_tick = (timer == LAST);

endmodule

// File: rtl/usb_tx_shift_ctrl.sv
// USB TX shift-register sequencer with bit stuffing and EOP generation.
// Stuffing is built only when USB_TX_BITSTUFF_EN is defined; otherwise it is a raw serializer.
module usb_tx_shift_ctrl
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              sr_load_enable,
    output logic              sr_shift_enable,
    output logic [BYTE_W-1:0] sr_parallel_in,
    input  logic              sr_serial_out,
    output logic              tx_bit,
    output logic              tx_se0,
    output logic              bit_tick,
    output logic              busy,
    output logic              tx_underrun
);

    tx_state_t  state, next_state;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       last_flag, last_flag_next;
    logic       stuff_hit;
    logic       timer_clear;
    logic       at_boundary;

`ifdef USB_TX_BITSTUFF_EN
    localparam int OW = $clog2(STUFF_LEN + 1);
    logic [OW-1:0] ones_cnt, ones_next, ones_upd;
    logic          stuff_eop, stuff_eop_next;

    assign ones_upd  = sr_serial_out ? ones_cnt + 1'b1 : '0;
    assign stuff_hit = (ones_upd == OW'(STUFF_LEN));
`else
    localparam int unused_stuff_len = STUFF_LEN;
    assign stuff_hit = 1'b0;
`endif

    // The timer restarts on every IDLE entry/exit so the first bit is a full period after the load.
    assign timer_clear    = (state == IDLE) || (next_state == IDLE);
    assign at_boundary    = (bit_cnt == 3'(BYTE_W - 1));
    assign sr_parallel_in = tx_data;
    assign busy           = (state != IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            last_flag <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
            ones_cnt  <= '0;
            stuff_eop <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            bit_cnt   <= bit_cnt_next;
            last_flag <= last_flag_next;
`ifdef USB_TX_BITSTUFF_EN
            ones_cnt  <= ones_next;
            stuff_eop <= stuff_eop_next;
`endif
        end
    end

    always_comb begin
        next_state      = state;
        bit_cnt_next    = bit_cnt;
        last_flag_next  = last_flag;
        tx_ready        = 1'b0;
        sr_load_enable  = 1'b0;
        sr_shift_enable = 1'b0;
        tx_bit          = 1'b1;
        tx_se0          = 1'b0;
        tx_underrun     = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
        ones_next       = ones_cnt;
        stuff_eop_next  = stuff_eop;
`endif

        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    sr_load_enable = 1'b1;
                    last_flag_next = tx_last;
                    bit_cnt_next   = '0;
`ifdef USB_TX_BITSTUFF_EN
                    ones_next      = '0;
                    stuff_eop_next = 1'b0;
`endif
                    next_state     = SHIFT;
                end
            end

            SHIFT: begin
                tx_bit = sr_serial_out;
                if (bit_tick) begin
`ifdef USB_TX_BITSTUFF_EN
                    ones_next = ones_upd;
`endif
                    if (!at_boundary) begin
                        sr_shift_enable = 1'b1;
                        bit_cnt_next    = bit_cnt + 3'd1;
                        next_state      = stuff_hit ? STUFF : SHIFT;
                    end else if (last_flag) begin
                        // A stuff bit still owed on the final bit must go out before the EOP.
                        bit_cnt_next = '0;
                        next_state   = stuff_hit ? STUFF : EOP_SE0;
`ifdef USB_TX_BITSTUFF_EN
                        stuff_eop_next = stuff_hit;
`endif
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            sr_load_enable = 1'b1;
                            bit_cnt_next   = '0;
                            last_flag_next = tx_last;
                            next_state     = stuff_hit ? STUFF : SHIFT;
                        end else begin
                            tx_underrun  = 1'b1;
                            bit_cnt_next = '0;
                            next_state   = EOP_SE0;
                        end
                    end
                end
            end

`ifdef USB_TX_BITSTUFF_EN
            STUFF: begin
                tx_bit    = 1'b0;
                ones_next = '0;
                if (bit_tick) begin
                    stuff_eop_next = 1'b0;
                    if (stuff_eop) begin
                        bit_cnt_next = '0;
                        next_state   = EOP_SE0;
                    end else begin
                        next_state   = SHIFT;
                    end
                end
            end
`endif

            EOP_SE0: begin
                tx_bit = 1'b0;
                tx_se0 = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt == 3'(EOP_SE0_BITS - 1)) begin
                        bit_cnt_next = '0;
                        next_state   = EOP_J;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end

            EOP_J: begin
                tx_bit = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt == 3'(EOP_J_BITS - 1)) begin
                        bit_cnt_next   = '0;
                        last_flag_next = 1'b0;
                        next_state     = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
